// File: rtl/chacha_pkg.sv
// Shared ChaCha20 definitions: sigma constants, round count, FSM states and
// the 16-word state type used by the block engine.
package chacha_pkg;

    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;

    localparam int CHACHA_ROUNDS = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUNDS,
        ST_FINAL,
        ST_DONE
    } state_e;

    // Word i of the ChaCha state lives at index i.
    typedef logic [15:0][31:0] chacha_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter-round on four 32-bit words.
module chacha_qr (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] a_rnd,
    output logic [31:0] b_rnd,
    output logic [31:0] c_rnd,
    output logic [31:0] d_rnd
);

    logic [31:0] a1, c1, d1, b1;
    logic [31:0] a2, c2, d2, b2;
    logic [31:0] dx1, bx1, dx2, bx2;

    assign a1  = a + b;
    assign dx1 = d ^ a1;
    assign d1  = {dx1[15:0], dx1[31:16]};
    assign c1  = c + d1;
    assign bx1 = b ^ c1;
    assign b1  = {bx1[19:0], bx1[31:20]};

    assign a2  = a1 + b1;
    assign dx2 = d1 ^ a2;
    assign d2  = {dx2[23:0], dx2[31:24]};
    assign c2  = c1 + d2;
    assign bx2 = b1 ^ c2;
    assign b2  = {bx2[24:0], bx2[31:25]};

    assign a_rnd = a2;
    assign b_rnd = b2;
    assign c_rnd = c2;
    assign d_rnd = d2;

endmodule

// File: rtl/chacha_core.sv
// ChaCha20 block engine: one round per clock, final add, then XOR with data_in.
module chacha_core
    import chacha_pkg::*;
#(
    parameter int ROUNDS = CHACHA_ROUNDS
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic [255:0] key,
    input  logic [63:0]  ctr,
    input  logic [63:0]  iv,
    input  logic [511:0] data_in,
    output logic         ready,
    output logic [511:0] data_out,
    output logic         data_out_valid
);

    localparam int RW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    // The reset port keeps its legacy name but is active-high.
    logic srst;
    assign srst = reset_n;

    state_e        state_reg, state_next;
    logic [255:0]  key_reg;
    logic [63:0]   iv_reg;
    logic [63:0]   ctr_reg;
    chacha_state_t init_state;
    chacha_state_t work_reg;
    chacha_state_t round_state;
    logic [RW-1:0] round_reg;
    logic [511:0]  keystream;
    logic [511:0]  data_out_reg;
    logic          valid_reg;
    logic          capture, start, do_round, do_final;
    logic          diag;

    logic [31:0] qr_a_rnd [4];
    logic [31:0] qr_b_rnd [4];
    logic [31:0] qr_c_rnd [4];
    logic [31:0] qr_d_rnd [4];

    always_comb begin
        init_state     = '0;
        init_state[0]  = SIGMA0;
        init_state[1]  = SIGMA1;
        init_state[2]  = SIGMA2;
        init_state[3]  = SIGMA3;
        for (int k = 0; k < 8; k++) begin
            init_state[4+k] = bswap32(key_reg[255-32*k -: 32]);
        end
        init_state[12] = ctr_reg[31:0];
        init_state[13] = ctr_reg[63:32];
        init_state[14] = bswap32(iv_reg[63:32]);
        init_state[15] = bswap32(iv_reg[31:0]);
    end

    // Even rounds work on columns, odd rounds on diagonals.
    assign diag = round_reg[0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_qr
            logic [31:0] qa, qb, qc, qd;
            assign qa = work_reg[gi];
            assign qb = diag ? work_reg[4+((gi+1)%4)]  : work_reg[4+gi];
            assign qc = diag ? work_reg[8+((gi+2)%4)]  : work_reg[8+gi];
            assign qd = diag ? work_reg[12+((gi+3)%4)] : work_reg[12+gi];

            chacha_qr u_qr (
                .a     (qa),
                .b     (qb),
                .c     (qc),
                .d     (qd),
                .a_rnd (qr_a_rnd[gi]),
                .b_rnd (qr_b_rnd[gi]),
                .c_rnd (qr_c_rnd[gi]),
                .d_rnd (qr_d_rnd[gi])
            );
        end
    endgenerate

    always_comb begin
        round_state = work_reg;
        for (int i = 0; i < 4; i++) begin
            round_state[i] = qr_a_rnd[i];
            if (diag) begin
                round_state[4+((i+1)%4)]  = qr_b_rnd[i];
                round_state[8+((i+2)%4)]  = qr_c_rnd[i];
                round_state[12+((i+3)%4)] = qr_d_rnd[i];
            end else begin
                round_state[4+i]  = qr_b_rnd[i];
                round_state[8+i]  = qr_c_rnd[i];
                round_state[12+i] = qr_d_rnd[i];
            end
        end
    end

    // Word 0 is serialized first, each word little-endian.
    always_comb begin
        keystream = '0;
        for (int i = 0; i < 16; i++) begin
            keystream[511-32*i -: 32] = bswap32(work_reg[i] + init_state[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        start      = 1'b0;
        do_round   = 1'b0;
        do_final   = 1'b0;
        ready      = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                ready = 1'b1;
                if (init) begin
                    capture    = 1'b1;
                    state_next = ST_IDLE;
                end else if (next) begin
                    start      = 1'b1;
                    state_next = ST_ROUNDS;
                end
            end
            ST_ROUNDS: begin
                do_round = 1'b1;
                if (round_reg == LAST_ROUND) begin
                    state_next = ST_FINAL;
                end
            end
            ST_FINAL: begin
                do_final   = 1'b1;
                state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            key_reg      <= '0;
            iv_reg       <= '0;
            ctr_reg      <= '0;
            work_reg     <= '0;
            round_reg    <= '0;
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
        end else begin
            if (capture) begin
                key_reg   <= key;
                iv_reg    <= iv;
                ctr_reg   <= ctr;
                valid_reg <= 1'b0;
            end
            if (start) begin
                work_reg  <= init_state;
                round_reg <= '0;
                valid_reg <= 1'b0;
            end
            if (do_round) begin
                work_reg  <= round_state;
                round_reg <= round_reg + 1'b1;
            end
            if (do_final) begin
                data_out_reg <= data_in ^ keystream;
                valid_reg    <= 1'b1;
            end
        end
    end

    assign data_out       = data_out_reg;
    assign data_out_valid = valid_reg;

endmodule

// File: tb/tb_chacha_core.sv
// Self-checking bench for chacha_core: known-answer table plus random blocks
// compared with a byte-level software ChaCha20 model.
module tb_chacha_core;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         init;
    logic         next;
    logic [255:0] key;
    logic [63:0]  ctr;
    logic [63:0]  iv;
    logic [511:0] data_in;
    logic         ready;
    logic [511:0] data_out;
    logic         data_out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [511:0] ZERO_KS = 512'h76b8e0ada0f13d90405d6ae55386bd28bdd219b8a08ded1aa836efcc8b770dc7da41597c5157488d7724e03fb8d84a376a43b8f41518a11cc387b669b2ee6586;

    localparam int QI [8][4] = '{
        '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}
    };

    typedef struct {
        bit           use_init;
        logic [255:0] key;
        logic [63:0]  iv;
        logic [63:0]  ctr;
        logic [511:0] din;
        logic [511:0] exp;
        logic [511:0] mask;
    } vec_t;

    vec_t vecs[3];

    chacha_core dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .init           (init),
        .next           (next),
        .key            (key),
        .ctr            (ctr),
        .iv             (iv),
        .data_in        (data_in),
        .ready          (ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] le_word(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    // Software ChaCha20 keystream block from byte-oriented key/nonce.
    function automatic logic [511:0] ref_keystream(input logic [255:0] k, input logic [63:0] n,
                                                   input logic [63:0] c);
        logic [7:0]   kb [32];
        logic [7:0]   nb [8];
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [31:0]  a, b, cc, d, w;
        logic [511:0] out;
        for (int j = 0; j < 32; j++) kb[j] = k[255-8*j -: 8];
        for (int j = 0; j < 8; j++) nb[j] = n[63-8*j -: 8];
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int j = 0; j < 8; j++) s[4+j] = le_word(kb[4*j], kb[4*j+1], kb[4*j+2], kb[4*j+3]);
        s[12] = c[31:0];
        s[13] = c[63:32];
        s[14] = le_word(nb[0], nb[1], nb[2], nb[3]);
        s[15] = le_word(nb[4], nb[5], nb[6], nb[7]);
        x = s;
        for (int r = 0; r < 10; r++) begin
            for (int q = 0; q < 8; q++) begin
                a = x[QI[q][0]]; b = x[QI[q][1]]; cc = x[QI[q][2]]; d = x[QI[q][3]];
                a = a + b;  d = rotl(d ^ a, 16);
                cc = cc + d; b = rotl(b ^ cc, 12);
                a = a + b;  d = rotl(d ^ a, 8);
                cc = cc + d; b = rotl(b ^ cc, 7);
                x[QI[q][0]] = a; x[QI[q][1]] = b; x[QI[q][2]] = cc; x[QI[q][3]] = d;
            end
        end
        out = '0;
        for (int i = 0; i < 16; i++) begin
            w = x[i] + s[i];
            for (int bb = 0; bb < 4; bb++) out[511-8*(4*i+bb) -: 8] = w[8*bb +: 8];
        end
        return out;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Optional init, then next; follows the block to data_out_valid and checks it.
    task automatic check_block(input string name, input bit use_init, input logic [255:0] k,
                               input logic [63:0] n, input logic [63:0] c,
                               input logic [511:0] din, input logic [511:0] exp);
        int lat;
        bit bad;
        @(negedge clk);
        key = k; iv = n; ctr = c; data_in = din;
        if (use_init) begin
            init = 1'b1;
            @(negedge clk);
            init = 1'b0;
        end
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        lat = 0;
        bad = 1'b0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (data_out_valid) break;
            if (ready) bad = 1'b1;
        end
        check({name, ".latency"}, 512'(lat), 512'd21);
        check({name, ".ready_low_while_busy"}, 512'(bad), 512'd0);
        check({name, ".ready_after_valid"}, 512'(ready), 512'd1);
        check({name, ".data_out"}, data_out, exp);
        $display("block %s: latency %0d data_out[511:448] %h", name, lat, data_out[511:448]);
    endtask

    initial begin
        logic [255:0] ka, kb, kfix;
        logic [63:0]  na, nb, ca, cb;
        logic [511:0] din;
        int           lat;
        bit           bad;

        vecs[0] = '{1'b0, 256'h0, 64'h0, 64'h0, 512'h0, ZERO_KS, {512{1'b1}}};
        vecs[1] = '{1'b1, 256'h0, 64'h0, 64'h1, 512'h0,
                    {128'h9f07e7be5551387a98ba977c732d080d, 384'h0}, {{128{1'b1}}, 384'h0}};
        vecs[2] = '{1'b1, 256'h0, 64'h0, 64'h0, ZERO_KS, 512'h0, {512{1'b1}}};

        init = 1'b0; next = 1'b0; key = '0; iv = '0; ctr = '0; data_in = '0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("reset.ready", 512'(ready), 512'd1);
        check("reset.valid", 512'(data_out_valid), 512'd0);
        check("reset.data_out", data_out, 512'h0);

        for (int v = 0; v < 3; v++) begin
            check_block($sformatf("vec%0d", v), vecs[v].use_init, vecs[v].key, vecs[v].iv,
                        vecs[v].ctr, vecs[v].din,
                        ref_keystream(vecs[v].key, vecs[v].iv, vecs[v].ctr) ^ vecs[v].din);
            check($sformatf("vec%0d.known_answer", v), data_out & vecs[v].mask,
                  vecs[v].exp & vecs[v].mask);
        end

        // Commands while busy must be ignored.
        ka = rand256(); na = {$urandom, $urandom}; ca = {$urandom, $urandom};
        kb = ~ka; nb = ~na; cb = ~ca;
        din = rand512();
        @(negedge clk);
        key = ka; iv = na; ctr = ca; data_in = din; init = 1'b1;
        @(negedge clk);
        init = 1'b0; next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        lat = 0;
        bad = 1'b0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (data_out_valid) break;
            if (ready) bad = 1'b1;
            @(negedge clk);
            init = 1'b0;
            next = 1'b0;
            if (lat == 5) begin
                key = kb; iv = nb; ctr = cb; init = 1'b1;
            end else if (lat == 10) begin
                next = 1'b1;
            end else if (lat == 15) begin
                init = 1'b1; next = 1'b1;
            end
        end
        check("busy.latency", 512'(lat), 512'd21);
        check("busy.ready_low", 512'(bad), 512'd0);
        check("busy.data_out", data_out, ref_keystream(ka, na, ca) ^ din);
        check_block("busy.key_kept", 1'b0, kb, nb, cb, din, ref_keystream(ka, na, ca) ^ din);

        // init+next together while ready: capture only, no block.
        @(negedge clk);
        key = kb; iv = nb; ctr = cb; init = 1'b1; next = 1'b1;
        @(negedge clk);
        init = 1'b0; next = 1'b0;
        check("both.valid_cleared", 512'(data_out_valid), 512'd0);
        check("both.ready", 512'(ready), 512'd1);
        bad = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (data_out_valid || !ready) bad = 1'b1;
        end
        check("both.no_block_started", 512'(bad), 512'd0);
        check_block("both.captured", 1'b0, ka, na, ca, din, ref_keystream(kb, nb, cb) ^ din);

        kfix = {4{64'h0123456789abcdef}};
        for (int c = 0; c < 10; c++) begin
            din = rand512();
            check_block($sformatf("b2b_ctr%0d", c), 1'b1, kfix, 64'hdeadbeefcafebabe, 64'(c), din,
                        ref_keystream(kfix, 64'hdeadbeefcafebabe, 64'(c)) ^ din);
        end

        for (int r = 0; r < 4; r++) begin
            ka = rand256(); na = {$urandom, $urandom}; ca = {$urandom, $urandom};
            din = rand512();
            check_block($sformatf("rand%0d", r), 1'b1, ka, na, ca, din,
                        ref_keystream(ka, na, ca) ^ din);
        end

        // Reset in the middle of the rounds aborts the block and clears the key.
        @(negedge clk);
        key = ka; iv = na; ctr = ca; init = 1'b1;
        @(negedge clk);
        init = 1'b0; next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        repeat (8) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        check("midreset.valid", 512'(data_out_valid), 512'd0);
        check("midreset.ready", 512'(ready), 512'd1);
        check("midreset.data_out", data_out, 512'h0);
        bad = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (data_out_valid || !ready) bad = 1'b1;
        end
        check("midreset.stays_idle", 512'(bad), 512'd0);
        check_block("midreset.zero_key", 1'b0, ka, na, ca, 512'h0, ZERO_KS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
